serial_borrow_subtractor: RTL and testbench
===========================================

SERIAL_BORROW_SUBTRACTOR -- requirements
Module: serial_borrow_subtractor

Interface
REQ-001 The block SHALL have one parameter: WIDTH, default 4, the operand width in bits (minimum 2).
REQ-002 clk  input  1  single clock; all state SHALL update on its rising edge.
REQ-003 rst_n  input  1  reset, asynchronous, active-low.
REQ-004 start  input  1  request pulse; sampled only in IDLE or DONE.
REQ-005 A  input  WIDTH  minuend; sampled on the accepting edge only.
REQ-006 B  input  WIDTH  subtrahend; sampled on the accepting edge only.
REQ-007 Bin  input  1  borrow-in; sampled on the accepting edge only.
REQ-008 busy  output  1  high while a subtraction is in progress.
REQ-009 done  output  1  one-cycle pulse when a result is published.
REQ-010 Diff  output  WIDTH  difference result, held until the next publish.
REQ-011 Bout  output  1  borrow-out result, held until the next publish.

Function
REQ-012 The FSM SHALL have three states: IDLE, RUN and DONE.
REQ-013 Accepting edge: a rising edge with start=1 while in IDLE or DONE.
- Captures A, B and Bin into internal registers.
- Loads the bit counter with 0 and the borrow register with Bin.
- Moves the FSM to RUN.
REQ-014 In RUN, each rising edge SHALL process exactly one bit position, LSB first.
- Per-bit rule: d = a XOR b XOR br.
- Next borrow: br' = (NOT a AND b) OR (NOT(a XOR b) AND br).
- d is shifted into an internal result register and the counter increments.
REQ-015 On the RUN edge that processes bit WIDTH-1, the block SHALL do all of the following on that same edge:
- Load Diff with the complete result.
- Load Bout with the final borrow.
- Move the FSM to DONE.
REQ-016 Latency: done SHALL be high in the cycle following the WIDTH-th edge after the accepting edge (4 cycles for WIDTH=4).
REQ-017 busy SHALL be 1 exactly when the FSM is in RUN; done SHALL be 1 exactly when the FSM is in DONE.
REQ-018 DONE SHALL last one cycle.
- If start=0, the FSM returns to IDLE.
- If start=1, the edge is an accepting edge and the FSM goes to RUN (back-to-back operation, no idle gap).
REQ-019 start during RUN SHALL be ignored; the captured operands and the in-flight computation SHALL NOT change.
REQ-020 Changes on A, B and Bin outside an accepting edge SHALL NOT affect busy, done, Diff or Bout.
REQ-021 Arithmetic: {Bout, Diff} SHALL equal (A - B - Bin) modulo 2^(WIDTH+1).
- Bout=1 if and only if A < B + Bin (unsigned).
- Underflow wraps Diff modulo 2^WIDTH.
REQ-022 Diff and Bout SHALL change only on the edge entering DONE, or on reset.
REQ-023 In IDLE with start=0, the block SHALL hold all state indefinitely.

Reset
REQ-024 While rst_n=0, regardless of clk, the block SHALL force all of the following:
- FSM to IDLE; busy=0; done=0.
- Diff=0; Bout=0.
- Counter, borrow register and operand registers to 0.
REQ-025 Reset asserted mid-RUN SHALL abort the operation; no done pulse and no partial result SHALL appear.
REQ-026 After rst_n rises, the first rising edge with start=1 SHALL be an accepting edge.

Verification
REQ-027 The bench SHALL cover at least these directed scenarios (WIDTH=4):
- Reset, then A=0000 B=0000 Bin=0 -> done after 4 cycles; Diff=0000, Bout=0; busy high for exactly 4 cycles.
- A=0101 B=0011 Bin=0 -> Diff=0010 Bout=0.
- A=0000 B=0001 Bin=0 -> Diff=1111 Bout=1 (wrap).
- A=1010 B=0101 Bin=1 -> Diff=0100 Bout=0; then A=1111 B=1111 Bin=1 started in the DONE cycle -> Diff=1111 Bout=1 exactly 4 cycles later.
- start pulsed and A/B changed during RUN -> result unchanged from the original operands; exactly one done pulse.
- rst_n low two cycles into RUN -> busy=0 immediately, Diff=0000 Bout=0, no done pulse; a subsequent operation produces a correct result.
REQ-028 The bench SHALL run a randomized sweep over all 512 (A, B, Bin) combinations, comparing each against a reference computation of A-B-Bin, and SHALL check the done pulse width and latency on every transaction.

Source files
------------

// File: rtl/serial_borrow_subtractor.sv
// Bit-serial subtractor: computes {Bout, Diff} = A - B - Bin one bit per clock, LSB first.
// A start in IDLE or DONE captures the operands; done pulses for one cycle when the result lands.
module serial_borrow_subtractor #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             Bin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] Diff,
  output logic             Bout
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

  state_t           state;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic             br;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] res;

  logic             d;
  logic             br_nxt;
  logic [WIDTH-1:0] res_nxt;

  // Operands shift right each RUN cycle, so bit 0 is always the current bit position.
  assign d       = a_q[0] ^ b_q[0] ^ br;
  assign br_nxt  = (~a_q[0] & b_q[0]) | (~(a_q[0] ^ b_q[0]) & br);
  assign res_nxt = {d, res[WIDTH-1:1]};

  // NOTE: every register here, including the operand and result storage, is cleared by the
  // asynchronous reset, and all state is assigned with <= so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      busy  <= 1'b0;
      done  <= 1'b0;
      a_q   <= '0;
      b_q   <= '0;
      br    <= 1'b0;
      cnt   <= '0;
      res   <= '0;
      Diff  <= '0;
      Bout  <= 1'b0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (start) begin
            a_q   <= A;
            b_q   <= B;
            br    <= Bin;
            cnt   <= '0;
            res   <= '0;
            state <= RUN;
            busy  <= 1'b1;
            done  <= 1'b0;
          end else begin
            state <= IDLE;
            busy  <= 1'b0;
            done  <= 1'b0;
          end
        end
        RUN: begin
          a_q <= a_q >> 1;
          b_q <= b_q >> 1;
          br  <= br_nxt;
          res <= res_nxt;
          cnt <= cnt + CW'(1);
          if (cnt == LAST_BIT) begin
            Diff  <= res_nxt;
            Bout  <= br_nxt;
            state <= DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
          done  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_serial_borrow_subtractor.sv
// Scoreboard bench for serial_borrow_subtractor: directed scenarios plus a shuffled sweep
// of every (A, B, Bin) combination, with done width, latency and busy length checked per result.
module tb_serial_borrow_subtractor;

  localparam int W = 4;

  typedef struct {
    logic [W:0] exp;
    int         acc;
  } item_t;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  logic [W-1:0] A = '0;
  logic [W-1:0] B = '0;
  logic         Bin = 1'b0;
  logic         busy;
  logic         done;
  logic [W-1:0] Diff;
  logic         Bout;

  item_t    sb_q[$];
  int       n_tests = 0;
  int       n_fail = 0;
  int       cyc = 0;
  int       busy_cnt = 0;
  logic     prev_done = 1'b0;
  logic [W:0] prev_out = '0;

  serial_borrow_subtractor #(.WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .A(A), .B(B), .Bin(Bin),
    .busy(busy), .done(done), .Diff(Diff), .Bout(Bout)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic logic [W:0] ref_sub(input logic [W-1:0] a, input logic [W-1:0] b,
                                         input logic bin);
    return {1'b0, a} - {1'b0, b} - {{W{1'b0}}, bin};
  endfunction

  // Monitor: samples 1 time unit after each rising edge.
  always @(posedge clk) begin
    item_t it;
    cyc++;
    #1;
    if (!rst_n) begin
      busy_cnt  = 0;
      prev_done = 1'b0;
      prev_out  = '0;
    end else begin
      if (prev_done) check("done_width", done, 1'b0);
      if (done) begin
        if (sb_q.size() == 0) begin
          check("spurious_done", done, 1'b0);
        end else begin
          it = sb_q.pop_front();
          check("diff", Diff, it.exp[W-1:0]);
          check("bout", Bout, it.exp[W]);
          check("latency", cyc - it.acc, W);
          check("busy_len", busy_cnt, W);
          check("busy_in_done", busy, 1'b0);
        end
        busy_cnt = 0;
      end else begin
        check("result_hold", {Bout, Diff}, prev_out);
        if (busy) busy_cnt++;
      end
      prev_done = done;
      prev_out  = {Bout, Diff};
    end
  end

  // Call at a falling edge; the next rising edge is the accepting edge.
  task automatic drive(input logic [W-1:0] a, input logic [W-1:0] b, input logic bin,
                       input logic [W:0] exp);
    item_t it;
    A = a; B = b; Bin = bin; start = 1'b1;
    it.exp = exp;
    it.acc = cyc + 1;
    sb_q.push_back(it);
    @(negedge clk);
    start = 1'b0;
  endtask

  // Returns at the falling edge inside the DONE cycle.
  task automatic wait_done();
    int n = 0;
    while (!done && n < 40) begin
      @(negedge clk);
      n++;
    end
    if (!done) check("timeout", 32'd0, 32'd1);
  endtask

  initial begin
    int order[512];
    int tmp, j;
    logic [W-1:0] ra, rb;
    logic rbin;

    // Reset state, checked while reset is still held.
    #12;
    check("rst_busy", busy, 1'b0);
    check("rst_done", done, 1'b0);
    check("rst_out", {Bout, Diff}, '0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Directed scenarios with spec-given results.
    drive(4'b0000, 4'b0000, 1'b0, 5'b0_0000); wait_done(); @(negedge clk);
    drive(4'b0101, 4'b0011, 1'b0, 5'b0_0010); wait_done(); @(negedge clk);
    drive(4'b0000, 4'b0001, 1'b0, 5'b1_1111); wait_done(); @(negedge clk);
    drive(4'b1010, 4'b0101, 1'b1, 5'b0_0100); wait_done();
    drive(4'b1111, 4'b1111, 1'b1, 5'b1_1111); wait_done(); @(negedge clk);
    check("idle_after_done", {busy, done}, 2'b00);

    // start and operand changes during RUN must be ignored.
    drive(4'b1001, 4'b0110, 1'b0, 5'b0_0011);
    A = 4'b0000; B = 4'b1111; Bin = 1'b1; start = 1'b1;
    @(negedge clk);
    A = 4'b0111; B = 4'b1000;
    @(negedge clk);
    start = 1'b0; A = 4'b1100; B = 4'b0001; Bin = 1'b0;
    wait_done(); @(negedge clk); @(negedge clk);
    check("single_done", done, 1'b0);

    // Reset two cycles into RUN: abort with no done pulse, outputs cleared at once.
    drive(4'b1100, 4'b0011, 1'b1, 5'b0_1000);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("abort_busy", busy, 1'b0);
    check("abort_done", done, 1'b0);
    check("abort_out", {Bout, Diff}, '0);
    sb_q.delete();
    @(negedge clk); @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("abort_no_done", done, 1'b0);
    drive(4'b0110, 4'b0111, 1'b0, 5'b1_1111); wait_done(); @(negedge clk);

    // Shuffled sweep over all (A, B, Bin) combinations, with random idle gaps (0 = back-to-back).
    for (int i = 0; i < 512; i++) order[i] = i;
    for (int i = 511; i > 0; i--) begin
      j = $urandom_range(i, 0);
      tmp = order[i]; order[i] = order[j]; order[j] = tmp;
    end
    for (int i = 0; i < 512; i++) begin
      tmp  = order[i];
      ra   = tmp[3:0];
      rb   = tmp[7:4];
      rbin = tmp[8];
      drive(ra, rb, rbin, ref_sub(ra, rb, rbin));
      wait_done();
      repeat ($urandom_range(2, 0)) @(negedge clk);
    end
    repeat (3) @(negedge clk);
    check("queue_empty", sb_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

endmodule
